mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port
// between the I-cache and D-cache, one transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_busy,
  output logic [1:0]        arb_grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [1:0]        grant;
  logic              last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;

  logic i_act;
  logic d_act;
  logic pick_d;
  logic busy;

  assign i_act  = i_mem_read | i_mem_write;
  assign d_act  = d_mem_read | d_mem_write;
  // D wins alone, or on a tie when I was served last
  assign pick_d = d_act & (~i_act | ~last_d);

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state   <= IDLE;
      grant   <= 2'b00;
      last_d  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_act | d_act) begin
            state <= BUSY;
            if (pick_d) begin
              grant   <= 2'b10;
              addr_q  <= d_mem_addr;
              wdata_q <= d_mem_wdata;
              wr_q    <= d_mem_write;
              rd_q    <= ~d_mem_write;
            end else begin
              grant   <= 2'b01;
              addr_q  <= i_mem_addr;
              wdata_q <= i_mem_wdata;
              wr_q    <= i_mem_write;
              rd_q    <= ~i_mem_write;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state  <= IDLE;
            last_d <= grant[1];
            grant  <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state == BUSY);
  assign arb_busy    = busy;
  assign arb_grant   = grant;
  assign mem_read    = busy & rd_q & ~mem_ready;
  assign mem_write   = busy & wr_q & ~mem_ready;
  assign mem_addr    = busy ? addr_q : '0;
  assign mem_wdata   = busy ? wdata_q : '0;
  assign i_mem_ready = busy & grant[0] & mem_ready;
  assign d_mem_ready = busy & grant[1] & mem_ready;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule
